// File: rtl/seg7_scan3.sv
// seg7_scan3: three-digit multiplexed 7-segment driver for BCD hundreds/tens/ones.
// A prescaler divides each digit slot into a blanking interval followed by a lit
// interval, and a three-state scan FSM steps ones -> tens -> hundreds. The BCD inputs
// are captured into shadow registers once per frame, so every frame shows one
// consistent value.
// Optional build macro SEG7_LZB_EN enables leading-zero blanking of the hundreds
// and tens digits.
module seg7_scan3 #(
  parameter int unsigned SCAN_DIV       = 50000,  // clocks per digit slot, >= BLANK_CYC+2
  parameter int unsigned BLANK_CYC      = 4,      // all-off clocks at start of a slot, >= 1
  parameter bit          SEG_ACTIVE_LOW = 1'b1,   // lit segment drives 0
  parameter bit          DIG_ACTIVE_LOW = 1'b1    // enabled digit drives 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hun,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  output logic [6:0] seg,
  output logic [2:0] dig,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  // XOR masks that turn active-high patterns into the pin polarity; also the "off" level.
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [2:0] DIG_OFF = {3{DIG_ACTIVE_LOW}};

  typedef enum logic [1:0] {S_ONE = 2'd0, S_TEN = 2'd1, S_HUN = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic [3:0]       sh_hun, sh_ten, sh_one;
  logic             slot_end;
  logic             snap;
  logic             lz_blank;
  logic [6:0]       seg_nxt;
  logic [2:0]       dig_nxt;
  logic             tick_nxt;

  // Active-high segment pattern, seg[0]=a .. seg[6]=g; non-BCD codes show a dash.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg7_decode = 7'h3F;
      4'd1:    seg7_decode = 7'h06;
      4'd2:    seg7_decode = 7'h5B;
      4'd3:    seg7_decode = 7'h4F;
      4'd4:    seg7_decode = 7'h66;
      4'd5:    seg7_decode = 7'h6D;
      4'd6:    seg7_decode = 7'h7D;
      4'd7:    seg7_decode = 7'h07;
      4'd8:    seg7_decode = 7'h7F;
      4'd9:    seg7_decode = 7'h6F;
      default: seg7_decode = 7'h40;
    endcase
  endfunction

  assign slot_end = (cnt == CNT_LAST);
  // The first edge after reset takes a snapshot so the first frame is not stale.
  assign snap     = first || (slot_end && (state == S_HUN));

  // Slot prescaler and the post-reset first-snapshot flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      first <= 1'b1;
    end else begin
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      first <= 1'b0;
    end
  end

  // Shadow digit registers, loaded only at a snapshot point.
  // NOTE: shadows are reset explicitly; they feed the display and must not power up as X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_hun <= '0;
      sh_ten <= '0;
      sh_one <= '0;
    end else if (snap) begin
      sh_hun <= hun;
      sh_ten <= ten;
      sh_one <= one;
    end
  end

`ifdef SEG7_LZB_EN
  // Leading-zero blanking: hide hundreds when it is 0, tens when both upper digits are 0.
  always_comb begin
    lz_blank = 1'b0;
    case (state)
      S_TEN:   lz_blank = (sh_hun == 4'd0) && (sh_ten == 4'd0);
      S_HUN:   lz_blank = (sh_hun == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_ONE;
    else      state <= state_nxt;
  end

  // Next state and next registered outputs: pick the digit, decode, blank, then apply polarity.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_nxt = state;
    seg_nxt   = SEG_OFF;
    dig_nxt   = DIG_OFF;
    tick_nxt  = (state == S_ONE) && (cnt == '0);
    case (state)
      S_ONE: begin
        if (slot_end) state_nxt = S_TEN;
        seg_nxt = seg7_decode(sh_one);
        dig_nxt = 3'b001;
      end
      S_TEN: begin
        if (slot_end) state_nxt = S_HUN;
        seg_nxt = seg7_decode(sh_ten);
        dig_nxt = 3'b010;
      end
      S_HUN: begin
        if (slot_end) state_nxt = S_ONE;
        seg_nxt = seg7_decode(sh_hun);
        dig_nxt = 3'b100;
      end
      default: begin
        state_nxt = S_ONE;
        seg_nxt   = 7'h00;
        dig_nxt   = 3'b000;
      end
    endcase
    if ((cnt < CNT_BLANK) || lz_blank) begin
      seg_nxt = 7'h00;
      dig_nxt = 3'b000;
    end
    seg_nxt = seg_nxt ^ SEG_OFF;
    dig_nxt = dig_nxt ^ DIG_OFF;
  end

  // Registered display outputs, one clock behind (state, cnt).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg        <= SEG_OFF;
      dig        <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dig        <= dig_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan3.sv
// tb_seg7_scan3: directed test of seg7_scan3 with SCAN_DIV=8, BLANK_CYC=2, active-low pins.
// Expectations are hand-computed segment codes; slot position within a 24-clock frame
// selects which digit (if any) should be lit. SEG7_LZB_EN changes the expected blanking.
module tb_seg7_scan3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hun, ten, one;
  logic [6:0] seg;
  logic [2:0] dig;
  logic       frame_tick;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SEG7_LZB_EN
  localparam logic [2:0] LZ_HUN = 3'b100;
  localparam logic [2:0] LZ_HT  = 3'b110;
`else
  localparam logic [2:0] LZ_HUN = 3'b000;
  localparam logic [2:0] LZ_HT  = 3'b000;
`endif

  seg7_scan3 #(
    .SCAN_DIV      (8),
    .BLANK_CYC     (2),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hun       (hun),
    .ten       (ten),
    .one       (one),
    .seg       (seg),
    .dig       (dig),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [6:0] e_seg,
                           input logic [2:0] e_dig, input logic e_ft);
    n_assert++;
    assert (seg === e_seg) else begin
      n_fail++;
      $error("FAIL %s seg: observed %h expected %h", tag, seg, e_seg);
    end
    n_assert++;
    assert (dig === e_dig) else begin
      n_fail++;
      $error("FAIL %s dig: observed %b expected %b", tag, dig, e_dig);
    end
    n_assert++;
    assert (frame_tick === e_ft) else begin
      n_fail++;
      $error("FAIL %s frame_tick: observed %b expected %b", tag, frame_tick, e_ft);
    end
  endtask

  // Check n consecutive output cycles starting at frame position p0 (0 = first clock of
  // the ones slot). s0/s1/s2 are the expected seg codes for ones/tens/hundreds; lzb marks
  // slots expected to stay dark for the whole slot.
  task automatic check_cycles(input int p0, input int n, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2,
                              input logic [2:0] lzb, input string tag);
    for (int k = 0; k < n; k++) begin
      int         p, slot, c;
      logic [6:0] e_seg;
      logic [2:0] e_dig;
      @(negedge clk);
      p    = (p0 + k) % 24;
      slot = p / 8;
      c    = p % 8;
      if (c < 2 || lzb[slot]) begin
        e_seg = 7'h7F;
        e_dig = 3'b111;
      end else begin
        e_dig = ~(3'b001 << slot);
        e_seg = (slot == 0) ? s0 : (slot == 1) ? s1 : s2;
      end
      check_out($sformatf("%s_p%0d", tag, p), e_seg, e_dig, p == 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    hun = 4'd1;
    ten = 4'd2;
    one = 4'd3;
    repeat (3) @(negedge clk);
    check_out("reset", 7'h7F, 3'b111, 1'b0);

    // Release: first snapshot on the next edge, frame_tick on that same output cycle.
    rst = 1'b1;
    check_cycles(0, 24, 7'h30, 7'h24, 7'h79, 3'b000, "f0_123");

    // Inputs change during the tens slot; this frame must keep showing 1/2/3.
    check_cycles(0, 10, 7'h30, 7'h24, 7'h79, 3'b000, "f1_123a");
    hun = 4'd4;
    ten = 4'd5;
    one = 4'd6;
    check_cycles(10, 14, 7'h30, 7'h24, 7'h79, 3'b000, "f1_123b");

    // New snapshot 4/5/6; next inputs 0/C/0 change mid-frame.
    check_cycles(0, 12, 7'h02, 7'h12, 7'h19, 3'b000, "f2_456a");
    hun = 4'd0;
    ten = 4'hC;
    one = 4'd0;
    check_cycles(12, 12, 7'h02, 7'h12, 7'h19, 3'b000, "f2_456b");

    // Non-BCD tens shows a dash; zeros show "0" (hundreds dark with blanking enabled).
    check_cycles(0, 12, 7'h40, 7'h3F, 7'h40, LZ_HUN, "f3_0c0a");
    hun = 4'd0;
    ten = 4'd0;
    one = 4'd7;
    check_cycles(12, 12, 7'h40, 7'h3F, 7'h40, LZ_HUN, "f3_0c0b");

    // 0/0/7: 7 = a,b,c; tens and hundreds show "0" or stay dark with blanking.
    check_cycles(0, 12, 7'h78, 7'h40, 7'h40, LZ_HT, "f4_007");

    // Asynchronous reset in the middle of the tens slot, between clock edges.
    rst = 1'b0;
    hun = 4'd9;
    ten = 4'd8;
    one = 4'd2;
    #1;
    check_out("async_rst", 7'h7F, 3'b111, 1'b0);
    repeat (2) @(negedge clk);
    check_out("rst_hold", 7'h7F, 3'b111, 1'b0);

    // Restart at ones with a fresh snapshot of 9/8/2.
    rst = 1'b1;
    check_cycles(0, 24, 7'h24, 7'h00, 7'h10, 3'b000, "f5_982");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan3.md
# seg7_scan3

Three-digit multiplexed 7-segment display driver for the watch datapath. Sits directly downstream of the binary-to-BCD converter and consumes its `hun`/`ten`/`one` BCD digits. A prescaler and a digit-scan state machine time-share one segment bus across three common digit enables. Inter-digit blanking suppresses ghosting, and the inputs are snapshotted once per frame so each frame shows one coherent value.

## Interface
- `SCAN_DIV`, 50000: clocks per digit slot; legal range ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, 4: clocks at the start of each slot with all digits off; legal range ≥ 1.
- `SEG_ACTIVE_LOW`, 1: 1 = lit segment drives 0.
- `DIG_ACTIVE_LOW`, 1: 1 = enabled digit drives 0.

Ports (reset `rst`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `hun`  in  4  BCD hundreds digit.
- `ten`  in  4  BCD tens digit.
- `one`  in  4  BCD ones digit.
- `seg`  out  7  segments; `seg[0]`=a … `seg[6]`=g.
- `dig`  out  3  digit enables; `dig[0]`=ones, `dig[1]`=tens, `dig[2]`=hundreds.
- `frame_tick`  out  1  one-cycle pulse when a new snapshot takes effect.

## Operation
- Prescaler `cnt` counts 0..`SCAN_DIV`-1 and wraps to 0. The wrap cycle (`cnt`==`SCAN_DIV`-1) is the slot end.
- Scan FSM states: S_ONE → S_TEN → S_HUN → S_ONE. The state advances only at slot end and is never skipped.
- Snapshot: shadow registers load `hun`/`ten`/`one` at the slot end in S_HUN. They also load on the first clock edge after `rst` deasserts, using a set-by-reset `first` flag cleared on that edge. Inputs are not sampled at any other time.
- Decode of the shadow digit selected by state:
  - 0–9 decode to the standard patterns, with 7 = a,b,c.
  - Values 10–15 show a dash (g only).
- Slot output:
  - During `cnt` < `BLANK_CYC`: all digits inactive and all segments off.
  - Otherwise: the state's digit is active and `seg` carries the decoded pattern.
- Polarity parameters are applied after decode and after blanking.
- All outputs are registered.
- Reset values:
  - `seg` = all off (7'h7F when `SEG_ACTIVE_LOW`=1).
  - `dig` = all inactive (3'b111 when `DIG_ACTIVE_LOW`=1).
  - `frame_tick` = 0.
  - `cnt` = 0, state = S_ONE, shadows = 0.
- Reset mid-operation forces the reset values immediately and asynchronously. Scan restarts at S_ONE with a fresh snapshot.

## Timing
- Outputs lag the internal (state, `cnt`) by one clock.
- Slot period = `SCAN_DIV` clocks: `BLANK_CYC` clocks all-off, then `SCAN_DIV`-`BLANK_CYC` clocks with one digit on.
- Frame period = 3×`SCAN_DIV` clocks. At most one `dig` bit is active in any cycle.
- `frame_tick` is high for exactly one clock, in the first output cycle of the S_ONE slot whose snapshot is new (including the first frame after reset).
- An input change is displayed in the first frame after the next snapshot. Changes at any other time within a frame never alter the current frame.
- Latency from an input change to display: at most 3×`SCAN_DIV`+`BLANK_CYC`+1 clocks.

## Configuration
- `SEG7_LZB_EN` defined (leading-zero blanking):
  - The hundreds slot is blanked (digit inactive, segments off) when shadow `hun`==0.
  - The tens slot is blanked when shadow `hun`==0 and `ten`==0.
  - The ones slot is never blanked.
  - Slot timing and FSM sequence are unchanged.
- Not defined: all three digits are always shown, with leading zeros displayed as "0".

## Test plan
- Reset: hold `rst`=0 → `seg`=7'h7F, `dig`=3'b111, `frame_tick`=0. Release → `frame_tick` pulses once within 2 clocks.
- `SCAN_DIV`=8, `BLANK_CYC`=2, inputs 1/2/3 →
  - `dig` cycles 3'b110, 3'b101, 3'b011, each for 6 clocks, with 3'b111 for 2 clocks before each.
  - `seg`=7'h30 during ones, 7'h24 during tens, 7'h79 during hundreds.
  - `frame_tick` period is 24 clocks.
- Change the inputs from 1/2/3 to 4/5/6 during the tens slot → the rest of the frame still shows 1/2/3. The next frame shows 6/5/4 with `seg` 7'h02/7'h12/7'h19.
- Inputs `hun`=0, `ten`=4'hC, `one`=0 → tens slot `seg`=7'h3F; the other slots show 7'h40 (macro off).
- Inputs 0/0/7:
  - With `SEG7_LZB_EN`: only `dig`=3'b110 is ever active, with `seg`=7'h78.
  - Without it: tens and hundreds slots show 7'h40.
- Assert `rst` mid-way through the tens slot → outputs go to reset values without waiting for a clock edge. After release the first active digit is ones, after `BLANK_CYC` blank clocks.
